// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encoding and
// the iteration-counter width helper.
package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  // Wide enough to hold 0..W so the counter never wraps inside BUSY.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mul_datapath.sv
// Shift-add datapath: accumulator, shifted multiplicand/multiplier and iteration count,
// driven by load/step strobes from the controlling FSM.
module seq_mul_datapath
  import mul_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [W-1:0]   mcand_i,
  input  logic [W-1:0]   mplr_i,
  output logic [2*W-1:0] acc_o,
  output logic           mplr_zero_o,
  output logic           last_iter_o
);

  localparam int unsigned CntW = cnt_width(W);

  logic [2*W-1:0]  acc_q, acc_d;
  logic [2*W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]    mplr_q, mplr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      acc_d   = '0;
      mcand_d = {{W{1'b0}}, mcand_i};
      mplr_d  = mplr_i;
      cnt_d   = '0;
    end else if (step_i) begin
      // acc is 2W bits wide and the true product fits, so no carry is lost.
      if (mplr_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
      cnt_d   = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign acc_o       = acc_q;
  assign mplr_zero_o = (mplr_q == '0);
  assign last_iter_o = (cnt_q == CntW'(W - 1));

endmodule

// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-add multiplier with start/busy/done handshake.
// Optional build macro SEQ_MUL_EARLY_TERM_EN finishes as soon as the multiplier runs out of set bits.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   multiplicand,
  input  logic [W-1:0]   multiplier,
  output logic [2*W-1:0] product,
  output logic           busy,
  output logic           done
);

  mul_state_e     state_q;
  logic [2*W-1:0] product_q;
  logic           busy_q;
  logic           done_q;

  logic           load;
  logic           step;
  logic           busy_fin;
  logic [2*W-1:0] acc;
  logic           mplr_zero;
  logic           last_iter;

  assign load = (state_q == ST_IDLE) && start;

`ifdef SEQ_MUL_EARLY_TERM_EN
  // A zero multiplier contributes nothing more, so skip the remaining iterations.
  assign step     = (state_q == ST_BUSY) && !mplr_zero;
  assign busy_fin = mplr_zero || last_iter;
`else
  logic unused_mplr_zero;
  assign unused_mplr_zero = mplr_zero;
  assign step     = (state_q == ST_BUSY);
  assign busy_fin = last_iter;
`endif

  seq_mul_datapath #(
    .W (W)
  ) u_datapath (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_i      (load),
    .step_i      (step),
    .mcand_i     (multiplicand),
    .mplr_i      (multiplier),
    .acc_o       (acc),
    .mplr_zero_o (mplr_zero),
    .last_iter_o (last_iter)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_BUSY;
            busy_q  <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (busy_fin) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          product_q <= acc;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized self-checking bench for seq_multiplier against an arithmetic reference model.
module tb_seq_multiplier;

  localparam int unsigned W       = 8;
  localparam int unsigned MaxWait = 40;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   mcand;
  logic [W-1:0]   mplr;
  logic [2*W-1:0] product;
  logic           busy;
  logic           done;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  seq_multiplier #(
    .W (W)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplr),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Edges from the accepting edge until done is visible.
  function automatic int unsigned exp_latency(input logic [W-1:0] b);
    int unsigned lat;
    lat = W + 1;
`ifdef SEQ_MUL_EARLY_TERM_EN
    begin
      int hi;
      hi = -1;
      for (int i = 0; i < int'(W); i++) if (b[i]) hi = i;
      if (hi < 0) lat = 2;
      else if (hi + 3 < int'(W + 1)) lat = hi + 3;
    end
`else
    if (b === 'x) lat = 0;
`endif
    return lat;
  endfunction

  function automatic int unsigned ref_product(input int unsigned a, input int unsigned b);
    return a * b;
  endfunction

  // Called at a negedge with DUT idle; returns at the negedge after the done pulse.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned j;
    bit          busy_ok;
    mcand = a;
    mplr  = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    busy_ok = busy;
    j       = 0;
    while (!done && j < MaxWait) begin
      @(posedge clk);
      @(negedge clk);
      j++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    check_eq({tag, "_latency"}, j, exp_latency(b));
    check_eq({tag, "_product"}, 32'(product), ref_product(a, b));
    check_eq({tag, "_busy"}, 32'(busy_ok), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int unsigned j;
    bit          flag;
    logic [W-1:0] a, b;

    rst   = 1'b1;
    start = 1'b0;
    mcand = '0;
    mplr  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("reset_product", 32'(product), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);

    run_op("m13x11", 8'd13, 8'd11);
    run_op("m255x255", 8'd255, 8'd255);
    run_op("m0x200", 8'd0, 8'd200);
    run_op("m200x1", 8'd200, 8'd1);
    run_op("m200x0", 8'd200, 8'd0);
    run_op("m1x128", 8'd1, 8'd128);

    for (int i = 0; i < 16; i++) begin
      run_op("rand", W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
    end

    // Start while busy must be ignored.
    mcand = 8'd7;
    mplr  = 8'd9;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    j     = 0;
    while (!done && j < MaxWait) begin
      @(posedge clk);
      @(negedge clk);
      j++;
      if (j == 2) begin
        mcand = 8'd100;
        mplr  = 8'd100;
        start = 1'b1;
      end else if (j == 3) begin
        start = 1'b0;
      end
    end
    check_eq("ignore_latency", j, exp_latency(8'd9));
    check_eq("ignore_product", 32'(product), 32'd63);
    flag = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (product !== 16'd63 || done !== 1'b0) flag = 1'b1;
    end
    check_eq("ignore_hold", 32'(flag), 32'd0);

    // Reset during an operation discards it.
    mcand = 8'd50;
    mplr  = 8'd50;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_product", 32'(product), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    flag = 1'b0;
    repeat (2 * W) begin
      @(posedge clk);
      @(negedge clk);
      if (done || busy) flag = 1'b1;
    end
    check_eq("abort_no_done", 32'(flag), 32'd0);
    run_op("m3x4", 8'd3, 8'd4);

    // Back-to-back with start held high.
    a     = W'($urandom_range(0, 255));
    b     = W'($urandom_range(0, 255));
    mcand = a;
    mplr  = b;
    start = 1'b1;
    for (int op = 0; op < 5; op++) begin
      j = 0;
      do begin
        @(posedge clk);
        @(negedge clk);
        j++;
      end while (!done && j <= MaxWait);
      check_eq("b2b_period", j, exp_latency(b) + 1);
      check_eq("b2b_product", 32'(product), ref_product(a, b));
      a     = W'($urandom_range(0, 255));
      b     = W'($urandom_range(0, 255));
      mcand = a;
      mplr  = b;
    end
    start = 1'b0;
    repeat (W + 4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
